booth_mul_seq: RTL and testbench
================================

# booth_mul_seq

Sequential, parametrised radix-4 Booth multiplier. It recodes the multiplier into Booth digits and accumulates one partial product per clock into a shifting accumulator. It supports signed and unsigned operands independently and uses a valid/ready handshake on both input and output. It sits in the mul subsystem as the area-optimised alternative to the fully parallel partial-product array, for datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, 16: operand width in bits.
  - Must be even and ≥ 4.
  - Any other value is an elaboration error.
- NDIG (derived, not overridable): WIDTH/2+1, the number of Booth digits processed per operation.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- a_signed  in  1  1: a is two's complement; 0: a is unsigned.
- b_signed  in  1  1: b is two's complement; 0: b is unsigned.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  exact product a*b, two's complement.
- busy  out  1  high in CALC and DONE.

## Operation
- States: IDLE, CALC, DONE.
- Transitions:
  - IDLE → CALC on in_valid && in_ready.
  - CALC → DONE after exactly NDIG CALC cycles.
  - DONE → IDLE on out_ready.
  - No other transitions.
- Accept (IDLE handshake) captures:
  - a extended to WIDTH+2 bits: sign-extended if a_signed, else zero-extended.
  - b extended to WIDTH+2 bits by the same rule, with an implicit 0 below its LSB.
  - a_signed, b_signed and the inputs are not sampled again until the next accept.
- Digit count: the extended b always yields NDIG digits, so latency does not depend on signedness. For a signed b, the top digit is 000 or 111, i.e. zero.
- Digit i uses bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0, mapped as:
  - 000, 111 → 0
  - 001, 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101, 110 → −A
  - where A is the extended a.
- Accumulation: acc += digit_i·A·4^i, in an accumulator at least 2*WIDTH+4 bits wide.
- Result: product = acc[2*WIDTH-1:0]. This is exact for all four signedness combinations; no overflow is possible.
- Output register:
  - product is loaded only on the CALC→DONE transition.
  - It holds its value in DONE and IDLE until the next completion.
- Control outputs:
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - Both are registered-state decodes, so no combinational path exists from in_valid/out_ready to either output.
- No in-flight abort exists other than rst_n.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - product=0, accumulator and digit counter = 0.
  - Outputs take these values while rst_n is low, independent of clk.
- Reset deassertion: the first accept is possible at the first rising edge with rst_n high.
- Latency: if accept occurs at edge E, out_valid rises after edge E+NDIG (9 cycles for WIDTH=16).
- Output hold: out_valid stays high, and product stays stable, until the edge where out_ready=1. out_valid falls after that edge.
- Throughput: one operation per NDIG+2 cycles minimum (accept, NDIG CALC, DONE with out_ready=1). The next accept is in the following IDLE cycle.
- Ignored inputs:
  - in_valid during CALC/DONE is ignored; the operands are not captured.
  - out_ready in IDLE/CALC is ignored.
- Reset mid-CALC or mid-DONE: the result is discarded, out_valid=0 immediately, and there is no spurious completion after release.
- Operand stability: a, b and the signed flags may change freely after the accept edge.

## Test plan
- WIDTH=16, signed×signed:
  - a=0x8000, b=0x8000 → product=0x40000000, out_valid 9 cycles after accept.
  - a=0xFFFF, b=0x0001 → 0xFFFFFFFF.
- WIDTH=16, unsigned×unsigned: a=0xFFFF, b=0xFFFF → product=0xFFFE0001. Also a=0, b=0xABCD → 0.
- WIDTH=16, mixed signedness:
  - a_signed=1, b_signed=0, a=0xFFFF, b=0xFFFF → product=0xFFFF0001 (−65535).
  - a_signed=0, b_signed=1, a=0x0003, b=0xFFFE → 0xFFFFFFFA.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → product stable, out_valid=1, in_ready=0 throughout.
  - Pulse in_valid during CALC → ignored, and the result matches the first operands.
- Reset mid-operation: assert rst_n low 4 cycles after accept →
  - out_valid=0, in_ready=1 and product=0 asynchronously.
  - The next operation after release completes correctly in 9 cycles.
- Random regression at WIDTH=4, 8, 16, 32:
  - ≥10k operations with random signedness and random out_ready/in_valid gaps.
  - product is compared to a reference model.
  - out_valid-to-accept spacing is always ≥ NDIG+2 cycles.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit is retired per clock into a wide accumulator.
// Both operands are widened by two bits at accept so signed and unsigned share one recoding path.
module booth_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               a_signed,
    input  logic               b_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int NDIG = WIDTH / 2 + 1;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int BW   = WIDTH + 3;
    localparam int CW   = $clog2(NDIG + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_mul_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACCW-1:0]    acc_q, acc_d;
    logic [ACCW-1:0]    mcand_q, mcand_d;
    logic [BW-1:0]      mplr_q, mplr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [ACCW-1:0]    pp;
    logic [ACCW-1:0]    acc_sum;
    logic               a_fill, b_fill;

    assign a_fill = a_signed & a[WIDTH-1];
    assign b_fill = b_signed & b[WIDTH-1];

    // mcand_q is pre-shifted by 4^i and mplr_q[2:0] is always the current digit window.
    always_comb begin
        pp = '0;
        unique case (mplr_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    assign acc_sum = acc_q + pp;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = CALC;
                    acc_d   = '0;
                    mcand_d = {{(ACCW-WIDTH){a_fill}}, a};
                    mplr_d  = {{2{b_fill}}, b, 1'b0};
                    cnt_d   = '0;
                end
            end
            CALC: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 2;
                mplr_d  = mplr_q >> 2;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d   = DONE;
                    cnt_d     = '0;
                    product_d = acc_sum[2*WIDTH-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed WIDTH=16 cases plus randomized regressions at WIDTH=4/8/16/32
// against an integer-arithmetic reference product.
module tb_booth_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: interpret each operand as a plain integer, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] av, input logic [31:0] bv,
                                            input bit as, input bit bs);
        longint x, y, p;
        logic [63:0] m;
        x = longint'(av);
        y = longint'(bv);
        if (as && av[w-1]) x = x - (longint'(1) <<< w);
        if (bs && bv[w-1]) y = y - (longint'(1) <<< w);
        p = x * y;
        m = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return 64'(p) & m;
    endfunction

    // ---------------- directed WIDTH=16 instance ----------------
    logic        d_rst_n     = 1'b1;
    logic        d_in_valid  = 1'b0;
    logic        d_in_ready;
    logic [15:0] d_a         = '0;
    logic [15:0] d_b         = '0;
    logic        d_a_s       = 1'b0;
    logic        d_b_s       = 1'b0;
    logic        d_out_valid;
    logic        d_out_ready = 1'b0;
    logic [31:0] d_product;
    logic        d_busy;
    bit          d_done      = 1'b0;

    booth_mul_seq #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (d_rst_n),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .a         (d_a),
        .b         (d_b),
        .a_signed  (d_a_s),
        .b_signed  (d_b_s),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .product   (d_product),
        .busy      (d_busy)
    );

    task automatic d_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input bit as, input bit bs, input logic [31:0] expv, input int hold);
        int k;
        check($sformatf("%s/in_ready", tag), 64'(d_in_ready), 64'd1);
        d_a = av; d_b = bv; d_a_s = as; d_b_s = bs; d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        d_a = ~av; d_b = 16'($urandom); d_a_s = ~as; d_b_s = ~bs;
        k = 0;
        while (!d_out_valid && k < 40) begin
            d_in_valid = (k == 2);
            @(posedge clk); #1;
            k++;
        end
        d_in_valid = 1'b0;
        check($sformatf("%s/latency", tag), 64'(k), 64'd9);
        check($sformatf("%s/product", tag), 64'(d_product), 64'(expv));
        check($sformatf("%s/busy", tag), 64'(d_busy), 64'd1);
        for (int i = 0; i < hold; i++) begin
            d_in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("%s/hold_valid", tag), 64'(d_out_valid), 64'd1);
            check($sformatf("%s/hold_ready", tag), 64'(d_in_ready), 64'd0);
            check($sformatf("%s/hold_product", tag), 64'(d_product), 64'(expv));
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        d_out_ready = 1'b0;
        check($sformatf("%s/drain_valid", tag), 64'(d_out_valid), 64'd0);
        check($sformatf("%s/drain_ready", tag), 64'(d_in_ready), 64'd1);
        check($sformatf("%s/idle_product", tag), 64'(d_product), 64'(expv));
        $display("op %s: a=%h b=%h as=%0d bs=%0d product=%h latency=%0d", tag, av, bv, as, bs, d_product, k);
    endtask

    task automatic d_reset_checks(input string tag);
        check($sformatf("%s/in_ready", tag), 64'(d_in_ready), 64'd1);
        check($sformatf("%s/out_valid", tag), 64'(d_out_valid), 64'd0);
        check($sformatf("%s/busy", tag), 64'(d_busy), 64'd0);
        check($sformatf("%s/product", tag), 64'(d_product), 64'd0);
    endtask

    initial begin
        int k;
        #1 d_rst_n = 1'b0;
        #2 d_reset_checks("por");
        @(posedge clk); #1;
        d_rst_n = 1'b1;

        d_op("ss_min",   16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000, 0);
        d_op("ss_neg1",  16'hFFFF, 16'h0001, 1'b1, 1'b1, 32'hFFFFFFFF, 0);
        d_op("uu_max",   16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, 5);
        d_op("uu_zero",  16'h0000, 16'hABCD, 1'b0, 1'b0, 32'h00000000, 1);
        d_op("su",       16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFF0001, 2);
        d_op("us",       16'h0003, 16'hFFFE, 1'b0, 1'b1, 32'hFFFFFFFA, 0);

        // Reset four cycles into CALC
        d_a = 16'h4321; d_b = 16'h1111; d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 d_rst_n = 1'b0;
        #1 d_reset_checks("rst_calc");
        repeat (2) @(posedge clk);
        #1 d_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("rst_calc/no_spurious", 64'(d_out_valid), 64'd0);
        end
        d_op("after_rst", 16'h1234, 16'h5678, 1'b0, 1'b0, 32'h06260060, 0);

        // Reset while a finished product is waiting in DONE
        d_a = 16'h7FFF; d_b = 16'h7FFF; d_a_s = 1'b1; d_b_s = 1'b1; d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        k = 0;
        while (!d_out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_done/pre_valid", 64'(d_out_valid), 64'd1);
        #2 d_rst_n = 1'b0;
        #1 d_reset_checks("rst_done");
        @(posedge clk); #1 d_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_done/no_spurious", 64'(d_out_valid), 64'd0);
        end
        d_op("ss_mixed", 16'h7FFF, 16'h8000, 1'b1, 1'b1, 32'hC0008000, 0);
        d_done = 1'b1;
    end

    // ---------------- randomized regressions ----------------
    localparam int NOPS = 2600;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rand
        localparam int W  = 4 << gi;
        localparam int ND = W / 2 + 1;

        logic           rst_n     = 1'b1;
        logic           in_valid  = 1'b0;
        logic           in_ready;
        logic [W-1:0]   a         = '0;
        logic [W-1:0]   b         = '0;
        logic           a_s       = 1'b0;
        logic           b_s       = 1'b0;
        logic           out_valid;
        logic           out_ready = 1'b0;
        logic [2*W-1:0] product;
        logic           busy;
        bit             done      = 1'b0;
        int             cyc       = 0;

        booth_mul_seq #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .a_signed  (a_s),
            .b_signed  (b_s),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .product   (product),
            .busy      (busy)
        );

        always @(posedge clk) cyc <= cyc + 1;

        function automatic logic [W-1:0] pick();
            logic [W-1:0] v;
            case ($urandom_range(0, 5))
                0:       v = '0;
                1:       v = '1;
                2:       v = {1'b1, {(W-1){1'b0}}};
                3:       v = {1'b0, {(W-1){1'b1}}};
                default: v = W'($urandom);
            endcase
            return v;
        endfunction

        initial begin
            int k, hold, gap, acc_cyc, last_cyc;
            logic [W-1:0] av, bv;
            bit as, bs;
            logic [63:0] expv;
            #1 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            last_cyc = 0;
            for (int n = 0; n < NOPS; n++) begin
                av = pick(); bv = pick();
                as = 1'($urandom); bs = 1'($urandom);
                expv = ref_mul(W, 32'(av), 32'(bv), as, bs);
                a = av; b = bv; a_s = as; b_s = bs; in_valid = 1'b1;
                check($sformatf("w%0d_in_ready", W), 64'(in_ready), 64'd1);
                @(posedge clk); #1;
                acc_cyc = cyc;
                if (n > 0)
                    check($sformatf("w%0d_spacing", W), 64'(acc_cyc - last_cyc >= ND + 2), 64'd1);
                last_cyc = acc_cyc;
                in_valid = 1'b0;
                a = W'($urandom); b = W'($urandom); a_s = 1'($urandom); b_s = 1'($urandom);
                k = 0;
                while (!out_valid && k < ND + 8) begin
                    in_valid  = 1'($urandom);
                    out_ready = 1'($urandom);
                    @(posedge clk); #1;
                    k++;
                end
                in_valid  = 1'b0;
                out_ready = 1'b0;
                check($sformatf("w%0d_latency", W), 64'(k), 64'(ND));
                check($sformatf("w%0d_product", W), 64'(product), expv);
                hold = $urandom_range(0, 3);
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk); #1;
                    check($sformatf("w%0d_hold_valid", W), 64'(out_valid), 64'd1);
                    check($sformatf("w%0d_hold_product", W), 64'(product), expv);
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                check($sformatf("w%0d_drain_valid", W), 64'(out_valid), 64'd0);
                check($sformatf("w%0d_idle_product", W), 64'(product), expv);
                gap = $urandom_range(0, 2);
                for (int i = 0; i < gap; i++) begin
                    @(posedge clk); #1;
                end
            end
            $display("width %0d: %0d random operations completed", W, NOPS);
            done = 1'b1;
        end
    end

    initial begin
        int guard;
        guard = 0;
        while (!(d_done && g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done)
               && guard < 95000) begin
            @(posedge clk);
            guard++;
        end
        check("all_done", 64'(d_done && g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
